// File: rtl/ram_wr_arbiter_pkg.sv
// Shared types and helpers for the RAM write-port arbiter and its round-robin picker.
package ram_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int log2ceil(input int n);
    int r;
    r = 32'sd0;
    for (int v = 32'sd1; v < n; v = v * 32'sd2) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Requester-side burst handshake bundle: requesters drive master, the arbiter is slave.
interface ram_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready
  );
endinterface

// File: rtl/ram_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after prio_ptr, modulo NREQ.
module rr_pick
  import ram_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = log2ceil(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   prio_ptr,
  output logic [GW-1:0]   winner,
  output logic            any_req
);

  localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);

  logic [GW:0] sum_s;
  logic [GW:0] idx_s;

  // Walk offsets from farthest to nearest so the closest request to prio_ptr wins.
  always_comb begin
    winner  = {GW{1'b0}};
    any_req = 1'b0;
    sum_s   = {(GW+1){1'b0}};
    idx_s   = {(GW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s   = {1'b0, prio_ptr} + (GW+1)'(k);
      idx_s   = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
      winner  = req[idx_s[GW-1:0]] ? idx_s[GW-1:0] : winner;
      any_req = any_req | req[idx_s[GW-1:0]];
    end
  end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Round-robin arbiter for the single RAM write port; grants are locked per burst with idle timeout.
module ram_wr_arbiter
  import ram_wr_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int IDLE_MAX = 7,
  parameter int AW       = log2ceil(DEPTH),
  parameter int GW       = log2ceil(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_wr_arbiter_if.slave        req_bus,
  output logic                   wenc,
  output logic [AW-1:0]          waddr,
  output logic [WIDTH-1:0]       wdata,
  output logic [GW-1:0]          gnt_id,
  output logic                   busy
);

  localparam int              IW        = log2ceil(IDLE_MAX + 1);
  localparam logic [IW-1:0]   IDLE_LAST = IW'(IDLE_MAX - 1);
  localparam logic [GW-1:0]   LAST_ID   = GW'(NREQ - 1);

  arb_state_t        state_r;
  logic [GW-1:0]     prio_ptr_r;
  logic [GW-1:0]     gnt_id_r;
  logic [IW-1:0]     idle_cnt_r;
  logic              wenc_r;
  logic [AW-1:0]     waddr_r;
  logic [WIDTH-1:0]  wdata_r;
  logic              busy_r;

  logic [GW-1:0]     winner_s;
  logic              any_s;
  logic [GW-1:0]     next_ptr_s;
  logic              beat_s;
  logic              last_s;
  logic [AW-1:0]     addr_sel_s;
  logic [WIDTH-1:0]  data_sel_s;
  logic [NREQ-1:0]   ready_s;

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req      (req_bus.req_valid),
    .prio_ptr (prio_ptr_r),
    .winner   (winner_s),
    .any_req  (any_s)
  );

  assign beat_s     = req_bus.req_valid[gnt_id_r];
  assign last_s     = req_bus.req_last[gnt_id_r];
  assign addr_sel_s = req_bus.req_addr[gnt_id_r * AW +: AW];
  assign data_sel_s = req_bus.req_data[gnt_id_r * WIDTH +: WIDTH];
  assign next_ptr_s = (gnt_id_r == LAST_ID) ? {GW{1'b0}} : (gnt_id_r + GW'(1));

  // Ready depends only on registered state so it never loops back through req_valid.
  always_comb begin
    ready_s = {NREQ{1'b0}};
    if (state_r == BURST) begin
      ready_s[gnt_id_r] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  assign req_bus.req_ready = ready_s;

  // Arbitration state, idle timeout and the registered RAM write pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prio_ptr_r <= {GW{1'b0}};
      gnt_id_r   <= {GW{1'b0}};
      idle_cnt_r <= {IW{1'b0}};
      wenc_r     <= 1'b0;
      waddr_r    <= {AW{1'b0}};
      wdata_r    <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wenc_r <= 1'b0;
          if (any_s) begin
            state_r    <= BURST;
            busy_r     <= 1'b1;
            gnt_id_r   <= winner_s;
            idle_cnt_r <= {IW{1'b0}};
          end
        end
        BURST: begin
          if (beat_s) begin
            wenc_r     <= 1'b1;
            waddr_r    <= addr_sel_s;
            wdata_r    <= data_sel_s;
            idle_cnt_r <= {IW{1'b0}};
            if (last_s) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              prio_ptr_r <= next_ptr_s;
            end
          end else begin
            wenc_r     <= 1'b0;
            idle_cnt_r <= idle_cnt_r + IW'(1);
            // The owner stalled too long: abandon its burst and move priority on.
            if (idle_cnt_r == IDLE_LAST) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              prio_ptr_r <= next_ptr_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          wenc_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wenc   = wenc_r;
  assign waddr  = waddr_r;
  assign wdata  = wdata_r;
  assign gnt_id = gnt_id_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Self-checking bench for ram_wr_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_ram_wr_arbiter;
  localparam int NREQ = 4, WIDTH = 8, DEPTH = 16, AW = 4, GW = 2, IDLE_MAX = 7;

  logic clk, rst, wenc, busy;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic [GW-1:0] gnt_id;
  int total = 0, bad = 0;

  ram_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  ram_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_MAX(IDLE_MAX)) dut (
    .clk(clk), .rst(rst), .req_bus(bus), .wenc(wenc), .waddr(waddr),
    .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester agents: per-requester beat lists, a read index and a stall flag.
  logic [AW-1:0]    bq_a [NREQ][32];
  logic [WIDTH-1:0] bq_d [NREQ][32];
  bit               bq_l [NREQ][32];
  int bi [NREQ];
  int bn [NREQ];
  bit hold [NREQ];
  logic [AW-1:0] obs_a [$];
  logic [WIDTH-1:0] obs_d [$];
  int gnt_log [$];
  logic busy_q;

  // Reference model: owner < 0 means nobody holds the grant.
  int m_owner, m_ptr, m_idle;
  logic [GW-1:0] m_gnt;
  logic m_wenc;
  logic [AW-1:0] m_waddr;
  logic [WIDTH-1:0] m_wdata;

  task automatic clear_agents();
    for (int i = 0; i < NREQ; i++) begin
      bi[i] = 0; bn[i] = 0; hold[i] = 1'b0;
    end
    obs_a.delete(); obs_d.delete(); gnt_log.delete();
  endtask

  task automatic add_beat(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input bit l);
    bq_a[i][bn[i]] = a; bq_d[i][bn[i]] = d; bq_l[i][bn[i]] = l;
    bn[i] = bn[i] + 1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (bi[i] < bn[i] && !hold[i]) begin
        bus.req_valid[i] = 1'b1;
        bus.req_last[i] = bq_l[i][bi[i]];
        bus.req_addr[i*AW +: AW] = bq_a[i][bi[i]];
        bus.req_data[i*WIDTH +: WIDTH] = bq_d[i][bi[i]];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    int i;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_gnt = '0;
      m_wenc = 1'b0; m_waddr = '0; m_wdata = '0;
    end else if (m_owner < 0) begin
      m_wenc = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (bus.req_valid[i] && m_owner < 0) begin
          m_owner = i; m_gnt = GW'(i); m_idle = 0;
        end
      end
    end else if (bus.req_valid[m_owner]) begin
      m_wenc = 1'b1;
      m_waddr = bus.req_addr[m_owner*AW +: AW];
      m_wdata = bus.req_data[m_owner*WIDTH +: WIDTH];
      m_idle = 0;
      if (bus.req_last[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end
    end else begin
      m_wenc = 1'b0;
      m_idle = m_idle + 1;
      if (m_idle == IDLE_MAX) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] acc;
    drive();
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (acc[i]) bi[i] = bi[i] + 1;
    if (wenc === 1'b1) begin
      obs_a.push_back(waddr); obs_d.push_back(wdata);
    end
    if (busy === 1'b1 && busy_q !== 1'b1) gnt_log.push_back(int'(gnt_id));
    busy_q = busy;
  endtask

  task automatic do_reset(input int n);
    clear_agents();
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (wenc !== 1'b0 || bus.req_ready !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 ||
          waddr !== 4'd0 || wdata !== 8'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: wenc=%b ready=%b busy=%b gnt=%0d waddr=%0h wdata=%0h want all zero",
                 c, wenc, bus.req_ready, busy, gnt_id, waddr, wdata);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [AW-1:0] ea [3];
    logic [WIDTH-1:0] ed [3];
    int guard;
    ea = '{4'd2, 4'd3, 4'd4};
    ed = '{8'hA1, 8'hA2, 8'hA3};
    do_reset(1);
    for (int k = 0; k < 3; k++) add_beat(1, ea[k], ed[k], (k == 2));
    tick();
    total++;
    if (busy !== 1'b1 || gnt_id !== 2'd1 || bus.req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL single_grant: busy=%b gnt=%0d ready=%b want 1/1/0010", busy, gnt_id, bus.req_ready);
    end
    guard = 0;
    while (bi[1] < 3 && guard < 20) begin tick(); guard++; end
    total++;
    if (busy !== 1'b0 || bi[1] != 3) begin
      bad++;
      $display("FAIL single_end: busy=%b beats=%0d want busy 0 after 3 beats", busy, bi[1]);
    end
    total++;
    if (obs_a.size() != 3) begin
      bad++;
      $display("FAIL single_count: got %0d writes want 3", obs_a.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_a[k] !== ea[k] || obs_d[k] !== ed[k]) begin
          bad++;
          $display("FAIL single_write%0d: got %0h/%0h want %0h/%0h", k, obs_a[k], obs_d[k], ea[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int guard;
    do_reset(1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) add_beat(i, 4'(i), 8'(16 * r + i), 1'b1);
    guard = 0;
    while ((bi[0] < 2 || bi[1] < 2 || bi[2] < 2 || bi[3] < 2) && guard < 60) begin
      tick(); guard++;
      total++;
      if ($countones(bus.req_ready) > 1) begin
        bad++;
        $display("FAIL contention_onehot: ready=%b want at most one bit", bus.req_ready);
      end
    end
    total++;
    if (gnt_log.size() != 8) begin
      bad++;
      $display("FAIL contention_grants: got %0d grants want 8", gnt_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (gnt_log[k] != k % NREQ) begin
          bad++;
          $display("FAIL contention_order%0d: got %0d want %0d", k, gnt_log[k], k % NREQ);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int guard;
    do_reset(1);
    add_beat(2, 4'd5, 8'h55, 1'b0);
    add_beat(2, 4'd6, 8'h66, 1'b1);
    add_beat(3, 4'd7, 8'h77, 1'b1);
    guard = 0;
    while (bi[2] == 0 && guard < 10) begin tick(); guard++; end
    hold[2] = 1'b1;
    for (int c = 1; c <= IDLE_MAX; c++) begin
      tick();
      total++;
      if (busy !== (c < IDLE_MAX) || wenc !== 1'b0) begin
        bad++;
        $display("FAIL timeout_stall%0d: busy=%b wenc=%b want busy=%b wenc=0", c, busy, wenc, (c < IDLE_MAX));
      end
    end
    tick();
    total++;
    if (busy !== 1'b1 || gnt_id !== 2'd3) begin
      bad++;
      $display("FAIL timeout_next: busy=%b gnt=%0d want 1/3", busy, gnt_id);
    end
    tick();
    total++;
    if (obs_a.size() != 2 || obs_a[0] !== 4'd5 || obs_a[1] !== 4'd7 || obs_d[1] !== 8'h77) begin
      bad++;
      $display("FAIL timeout_writes: got %0d writes want 5:55 then 7:77", obs_a.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    do_reset(1);
    for (int k = 0; k < 4; k++) add_beat(0, 4'(8 + k), 8'(8'hC0 + k), (k == 3));
    guard = 0;
    while (bi[0] < 1 && guard < 10) begin tick(); guard++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (wenc !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000 || gnt_id !== 2'd0 || waddr !== 4'd0) begin
      bad++;
      $display("FAIL midrst_state: wenc=%b busy=%b ready=%b gnt=%0d waddr=%0h want zeros",
               wenc, busy, bus.req_ready, gnt_id, waddr);
    end
    clear_agents();
    add_beat(1, 4'd1, 8'h11, 1'b1);
    add_beat(0, 4'd0, 8'h22, 1'b1);
    tick();
    total++;
    if (busy !== 1'b1 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL midrst_regrant: busy=%b gnt=%0d want 1/0", busy, gnt_id);
    end
    tick();
    total++;
    if (wenc !== 1'b1 || waddr !== 4'd0 || wdata !== 8'h22) begin
      bad++;
      $display("FAIL midrst_write: wenc=%b %0h/%0h want 1 0/22", wenc, waddr, wdata);
    end
  endtask

  task automatic test_wrap();
    int guard;
    do_reset(1);
    add_beat(3, 4'd3, 8'h31, 1'b0);
    add_beat(3, 4'd4, 8'h32, 1'b1);
    tick();
    total++;
    if (gnt_id !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_first: gnt=%0d busy=%b want 3/1", gnt_id, busy);
    end
    add_beat(0, 4'd9, 8'h09, 1'b1);
    add_beat(3, 4'd10, 8'h3A, 1'b1);
    guard = 0;
    while (bi[3] < 2 && guard < 10) begin tick(); guard++; end
    tick();
    total++;
    if (busy !== 1'b1 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL wrap_grant: busy=%b gnt=%0d want 1/0", busy, gnt_id);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_rdy;
    do_reset(2);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i]) hold[i] = ($urandom_range(0, 4) != 0);
        else hold[i] = ($urandom_range(0, 14) == 0);
        if (bi[i] >= bn[i] && $urandom_range(0, 2) == 0) begin
          int len;
          bi[i] = 0; bn[i] = 0;
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            add_beat(i, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), (k == len - 1));
        end
      end
      rst = ($urandom_range(0, 249) == 0);
      tick();
      exp_rdy = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      total++;
      if (wenc !== m_wenc || waddr !== m_waddr || wdata !== m_wdata || bus.req_ready !== exp_rdy ||
          busy !== (m_owner >= 0) || gnt_id !== m_gnt) begin
        bad++;
        $display("FAIL random c%0d: wenc=%b a=%0h d=%0h rdy=%b busy=%b gnt=%0d want %b %0h %0h %b %b %0d",
                 c, wenc, waddr, wdata, bus.req_ready, busy, gnt_id,
                 m_wenc, m_waddr, m_wdata, exp_rdy, (m_owner >= 0), m_gnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    busy_q = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_addr = '0; bus.req_data = '0;
    clear_agents();
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_contention();
    test_timeout();
    test_reset_mid_burst();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
